// File: rtl/multi_sram_pipe.sv
// Banked true-dual-port SRAM with a post-reset clear sweep and a configurable read pipeline.
// Port A wins same-address write/write collisions; a read that meets the other port's write gets the write data.
module multi_sram_pipe #(
    parameter int DWIDTH     = 32,
    parameter int NRAMWIDHT  = 5,
    parameter int AWIDTH     = 13,
    parameter int RD_LAT     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          en_a_in,
    input  logic                          we_a_in,
    input  logic [NRAMWIDHT+AWIDTH-1:0]   addr_a_in,
    input  logic [DWIDTH-1:0]             d_a_in,
    output logic                          rdy_a_out,
    output logic [DWIDTH-1:0]             d_a_out,
    output logic                          vld_a_out,
    input  logic                          en_b_in,
    input  logic                          we_b_in,
    input  logic [NRAMWIDHT+AWIDTH-1:0]   addr_b_in,
    input  logic [DWIDTH-1:0]             d_b_in,
    output logic                          rdy_b_out,
    output logic [DWIDTH-1:0]             d_b_out,
    output logic                          vld_b_out,
    output logic                          init_done_out,
    output logic                          collision_out
);

    localparam int NSRAM = 1 << NRAMWIDHT;
    localparam int WORDS = 1 << AWIDTH;
    localparam int AW    = NRAMWIDHT + AWIDTH;

    if ((RD_LAT < 1) || (RD_LAT > 3)) begin : g_bad_rd_lat
        $error("multi_sram_pipe: RD_LAT must be 1..3");
    end

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                state_r;
    logic [AWIDTH-1:0]     clr_cnt_r;
    logic                  init_done_r;
    logic                  collision_r;

    logic [DWIDTH-1:0]     mem_r   [NSRAM][WORDS];
    logic [DWIDTH-1:0]     q_r     [2][NSRAM];
    logic [1:0]            vld1_r;
    logic [NRAMWIDHT-1:0]  bank1_r [2];
    logic [1:0]            pv_r    [RD_LAT];
    logic [DWIDTH-1:0]     pd_r    [2][RD_LAT];

    logic [NRAMWIDHT-1:0]  bank_s  [2];
    logic [AWIDTH-1:0]     word_s  [2];
    logic [DWIDTH-1:0]     byp_d_s [2];
    logic [DWIDTH-1:0]     d1_s    [2];
    logic [1:0]            acc_s;
    logic [1:0]            rd_s;
    logic [1:0]            wr_s;
    logic [1:0]            wr_eff_s;
    logic [1:0]            byp_s;
    logic                  same_addr_s;
    logic                  coll_ww_s;
    logic                  clr_we_s;

    // Request decode: acceptance, bank/word split, collision and bypass detection.
    always_comb begin
        bank_s[0]   = addr_a_in[AW-1:AWIDTH];
        bank_s[1]   = addr_b_in[AW-1:AWIDTH];
        word_s[0]   = addr_a_in[AWIDTH-1:0];
        word_s[1]   = addr_b_in[AWIDTH-1:0];
        byp_d_s[0]  = d_b_in;
        byp_d_s[1]  = d_a_in;
        same_addr_s = (addr_a_in == addr_b_in);
        acc_s[0]    = en_a_in & init_done_r & rst_n_in;
        acc_s[1]    = en_b_in & init_done_r & rst_n_in;
        wr_s        = acc_s & {we_b_in, we_a_in};
        rd_s        = acc_s & ~{we_b_in, we_a_in};
        coll_ww_s   = wr_s[0] & wr_s[1] & same_addr_s;
        wr_eff_s    = {wr_s[1] & ~coll_ww_s, wr_s[0]};
        byp_s[0]    = rd_s[0] & wr_s[1] & same_addr_s;
        byp_s[1]    = rd_s[1] & wr_s[0] & same_addr_s;
        clr_we_s    = (state_r == ST_CLEAR) & rst_n_in;
    end

    // Bank storage: the clear sweep writes one word in every bank, otherwise per-port writes.
    always_ff @(posedge clk_in) begin
        for (int b = 0; b < NSRAM; b++) begin
            if (clr_we_s) begin
                mem_r[b][clr_cnt_r] <= {DWIDTH{1'b0}};
            end else begin
                if (wr_eff_s[0] && (bank_s[0] == NRAMWIDHT'(b))) begin
                    mem_r[b][word_s[0]] <= d_a_in;
                end
                if (wr_eff_s[1] && (bank_s[1] == NRAMWIDHT'(b))) begin
                    mem_r[b][word_s[1]] <= d_b_in;
                end
            end
        end
    end

    // Per-bank read registers; only the addressed bank of a reading port is enabled.
    always_ff @(posedge clk_in) begin
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < NSRAM; b++) begin
                if (rd_s[p] && (bank_s[p] == NRAMWIDHT'(b))) begin
                    q_r[p][b] <= byp_s[p] ? byp_d_s[p] : mem_r[b][word_s[p]];
                end
            end
        end
    end

    // Read-stage control: valid and bank index travel with the bank read.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            vld1_r     <= 2'b00;
            bank1_r[0] <= {NRAMWIDHT{1'b0}};
            bank1_r[1] <= {NRAMWIDHT{1'b0}};
        end else begin
            vld1_r     <= rd_s;
            bank1_r[0] <= bank_s[0];
            bank1_r[1] <= bank_s[1];
        end
    end

    // Bank select and zero-gating of read data.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            d1_s[p] = vld1_r[p] ? q_r[p][bank1_r[p]] : {DWIDTH{1'b0}};
        end
    end

    // Output pipeline: RD_LAT register stages, the last one drives the ports.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pv_r[s]    <= 2'b00;
                pd_r[0][s] <= {DWIDTH{1'b0}};
                pd_r[1][s] <= {DWIDTH{1'b0}};
            end
        end else begin
            pv_r[0]    <= vld1_r;
            pd_r[0][0] <= d1_s[0];
            pd_r[1][0] <= d1_s[1];
            for (int s = 1; s < RD_LAT; s++) begin
                pv_r[s]    <= pv_r[s-1];
                pd_r[0][s] <= pd_r[0][s-1];
                pd_r[1][s] <= pd_r[1][s-1];
            end
        end
    end

    // Clear/run sequencer with registered init_done and collision pulse.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_r     <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_r   <= {AWIDTH{1'b0}};
            init_done_r <= (CLR_ON_RST == 0);
            collision_r <= 1'b0;
        end else begin
            collision_r <= coll_ww_s;
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r   <= clr_cnt_r + {{(AWIDTH-1){1'b0}}, 1'b1};
                    init_done_r <= 1'b0;
                    if (clr_cnt_r == {AWIDTH{1'b1}}) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= ST_CLEAR;
                    end
                end
                ST_RUN: begin
                    state_r     <= ST_RUN;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    clr_cnt_r   <= {AWIDTH{1'b0}};
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign rdy_a_out     = init_done_r;
    assign rdy_b_out     = init_done_r;
    assign init_done_out = init_done_r;
    assign collision_out = collision_r;
    assign vld_a_out     = pv_r[RD_LAT-1][0];
    assign vld_b_out     = pv_r[RD_LAT-1][1];
    assign d_a_out       = pd_r[0][RD_LAT-1];
    assign d_b_out       = pd_r[1][RD_LAT-1];

endmodule

// File: tb/tb_multi_sram_pipe.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=3 instance share the same stimulus.
module tb_multi_sram_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, we_a, en_b, we_b;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] d_a, d_b;
    logic        l1_rdy_a, l1_vld_a, l1_rdy_b, l1_vld_b, l1_init, l1_coll;
    logic        l3_rdy_a, l3_vld_a, l3_rdy_b, l3_vld_b, l3_init, l3_coll;
    logic [31:0] l1_d_a, l1_d_b, l3_d_a, l3_d_b;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    multi_sram_pipe #(.DWIDTH(32), .NRAMWIDHT(2), .AWIDTH(4), .RD_LAT(1), .CLR_ON_RST(1)) u_dut_l1 (
        .clk_in(clk), .rst_n_in(rst_n),
        .en_a_in(en_a), .we_a_in(we_a), .addr_a_in(addr_a), .d_a_in(d_a),
        .rdy_a_out(l1_rdy_a), .d_a_out(l1_d_a), .vld_a_out(l1_vld_a),
        .en_b_in(en_b), .we_b_in(we_b), .addr_b_in(addr_b), .d_b_in(d_b),
        .rdy_b_out(l1_rdy_b), .d_b_out(l1_d_b), .vld_b_out(l1_vld_b),
        .init_done_out(l1_init), .collision_out(l1_coll));

    multi_sram_pipe #(.DWIDTH(32), .NRAMWIDHT(2), .AWIDTH(4), .RD_LAT(3), .CLR_ON_RST(1)) u_dut_l3 (
        .clk_in(clk), .rst_n_in(rst_n),
        .en_a_in(en_a), .we_a_in(we_a), .addr_a_in(addr_a), .d_a_in(d_a),
        .rdy_a_out(l3_rdy_a), .d_a_out(l3_d_a), .vld_a_out(l3_vld_a),
        .en_b_in(en_b), .we_b_in(we_b), .addr_b_in(addr_b), .d_b_in(d_b),
        .rdy_b_out(l3_rdy_b), .d_b_out(l3_d_b), .vld_b_out(l3_vld_b),
        .init_done_out(l3_init), .collision_out(l3_coll));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic we, input logic [5:0] addr, input logic [31:0] data);
        en_a = en; we_a = we; addr_a = addr; d_a = data;
    endtask

    task automatic set_b(input logic en, input logic we, input logic [5:0] addr, input logic [31:0] data);
        en_b = en; we_b = we; addr_b = addr; d_b = data;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 6'h00, 32'h0);
        set_b(1'b0, 1'b0, 6'h00, 32'h0);
    endtask

    task automatic test_reset();
        logic seen;
        seen = 1'b0;
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        checks++; if ({l1_init, l1_rdy_a, l1_rdy_b, l1_coll} !== 4'b0000) begin errors++; $display("FAIL rst_l1_ctrl: got %b want 0000", {l1_init, l1_rdy_a, l1_rdy_b, l1_coll}); end
        checks++; if ({l1_vld_a, l1_vld_b} !== 2'b00 || l1_d_a !== 32'h0 || l1_d_b !== 32'h0) begin errors++; $display("FAIL rst_l1_out: vld %b d_a %h d_b %h want 0", {l1_vld_a, l1_vld_b}, l1_d_a, l1_d_b); end
        checks++; if ({l3_init, l3_rdy_a, l3_rdy_b, l3_coll, l3_vld_a, l3_vld_b} !== 6'b000000) begin errors++; $display("FAIL rst_l3_ctrl: got %b want 000000", {l3_init, l3_rdy_a, l3_rdy_b, l3_coll, l3_vld_a, l3_vld_b}); end
        rst_n = 1'b1;
        set_a(1'b1, 1'b0, 6'h2F, 32'h0);
        set_b(1'b1, 1'b1, 6'h10, 32'h12345678);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 10) idle();
            seen = seen | l1_vld_a | l1_vld_b | l3_vld_a | l3_vld_b;
            if (i == 15) begin
                checks++; if ({l1_init, l3_init, l1_rdy_a, l3_rdy_b} !== 4'b0000) begin errors++; $display("FAIL clear_15: init/rdy %b want 0000", {l1_init, l3_init, l1_rdy_a, l3_rdy_b}); end
            end
        end
        checks++; if ({l1_init, l1_rdy_a, l1_rdy_b, l3_init} !== 4'b1111) begin errors++; $display("FAIL clear_16: init/rdy %b want 1111", {l1_init, l1_rdy_a, l1_rdy_b, l3_init}); end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clear_ignore: vld seen %b want 0", seen); end
    endtask

    task automatic test_clear_read();
        set_a(1'b1, 1'b0, 6'h2F, 32'h0);
        set_b(1'b1, 1'b0, 6'h10, 32'h0);
        tick();
        idle();
        checks++; if (l1_vld_a !== 1'b0) begin errors++; $display("FAIL clrrd_t0: vld %b want 0", l1_vld_a); end
        tick();
        checks++; if (l1_vld_a !== 1'b1 || l1_d_a !== 32'h0) begin errors++; $display("FAIL clrrd_t1: vld %b d %h want 1 00000000", l1_vld_a, l1_d_a); end
        checks++; if (l1_vld_b !== 1'b1 || l1_d_b !== 32'h0) begin errors++; $display("FAIL clrrd_ign_wr: vld %b d %h want 1 00000000", l1_vld_b, l1_d_b); end
        tick();
        checks++; if (l1_vld_a !== 1'b0) begin errors++; $display("FAIL clrrd_t2: vld %b want 0", l1_vld_a); end
        tick();
        checks++; if (l3_vld_a !== 1'b1 || l3_d_a !== 32'h0) begin errors++; $display("FAIL clrrd_l3: vld %b d %h want 1 00000000", l3_vld_a, l3_d_a); end
    endtask

    task automatic test_rd_latency();
        logic        ev;
        logic [31:0] ed;
        set_a(1'b1, 1'b1, 6'h13, 32'hDEADBEEF);
        tick();
        checks++; if (l1_vld_a !== 1'b0) begin errors++; $display("FAIL wr_novld: vld %b want 0", l1_vld_a); end
        set_a(1'b1, 1'b0, 6'h13, 32'h0);
        tick();
        idle();
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            ev = (k == 3);
            ed = ev ? 32'hDEADBEEF : 32'h0;
            checks++; if (l3_vld_a !== ev || l3_d_a !== ed) begin errors++; $display("FAIL lat3_k%0d: vld %b d %h want %b %h", k, l3_vld_a, l3_d_a, ev, ed); end
            ev = (k == 1);
            ed = ev ? 32'hDEADBEEF : 32'h0;
            checks++; if (l1_vld_a !== ev || l1_d_a !== ed) begin errors++; $display("FAIL lat1_k%0d: vld %b d %h want %b %h", k, l1_vld_a, l1_d_a, ev, ed); end
        end
    endtask

    task automatic test_collision();
        set_a(1'b1, 1'b1, 6'h05, 32'h11111111);
        set_b(1'b1, 1'b1, 6'h05, 32'h22222222);
        tick();
        idle();
        checks++; if (l1_coll !== 1'b1 || l3_coll !== 1'b1) begin errors++; $display("FAIL coll_pulse: l1 %b l3 %b want 1 1", l1_coll, l3_coll); end
        tick();
        checks++; if (l1_coll !== 1'b0) begin errors++; $display("FAIL coll_end: %b want 0", l1_coll); end
        set_a(1'b1, 1'b0, 6'h05, 32'h0);
        set_b(1'b1, 1'b0, 6'h05, 32'h0);
        tick();
        idle();
        checks++; if (l1_coll !== 1'b0) begin errors++; $display("FAIL rr_nocoll: %b want 0", l1_coll); end
        tick();
        checks++; if (l1_vld_a !== 1'b1 || l1_d_a !== 32'h11111111) begin errors++; $display("FAIL coll_rd_a: vld %b d %h want 1 11111111", l1_vld_a, l1_d_a); end
        checks++; if (l1_vld_b !== 1'b1 || l1_d_b !== 32'h11111111) begin errors++; $display("FAIL coll_rd_b: vld %b d %h want 1 11111111", l1_vld_b, l1_d_b); end
    endtask

    task automatic test_bypass();
        set_a(1'b1, 1'b1, 6'h3A, 32'hCAFEF00D);
        set_b(1'b1, 1'b0, 6'h3A, 32'h0);
        tick();
        idle();
        checks++; if (l1_coll !== 1'b0) begin errors++; $display("FAIL byp_nocoll: %b want 0", l1_coll); end
        tick();
        checks++; if (l1_vld_b !== 1'b1 || l1_d_b !== 32'hCAFEF00D || l1_vld_a !== 1'b0) begin errors++; $display("FAIL byp_b: vld_b %b d_b %h vld_a %b want 1 cafef00d 0", l1_vld_b, l1_d_b, l1_vld_a); end
        tick();
        tick();
        checks++; if (l3_vld_b !== 1'b1 || l3_d_b !== 32'hCAFEF00D) begin errors++; $display("FAIL byp_b_l3: vld %b d %h want 1 cafef00d", l3_vld_b, l3_d_b); end
        set_a(1'b1, 1'b0, 6'h3B, 32'h0);
        set_b(1'b1, 1'b1, 6'h3B, 32'h0BADF00D);
        tick();
        idle();
        tick();
        checks++; if (l1_vld_a !== 1'b1 || l1_d_a !== 32'h0BADF00D) begin errors++; $display("FAIL byp_a: vld %b d %h want 1 0badf00d", l1_vld_a, l1_d_a); end
    endtask

    task automatic test_back_to_back();
        logic        ev, cseen;
        logic [31:0] ed;
        int          run;
        cseen = 1'b0;
        run = 0;
        for (int i = 0; i < 16; i++) begin
            set_a(1'b1, 1'b1, 6'(i), 32'hA5000000 | 32'(i));
            tick();
        end
        for (int j = 0; j < 18; j++) begin
            if (j < 16) begin
                set_a(1'b1, 1'b0, 6'(j), 32'h0);
                set_b(1'b1, 1'b1, 6'h30 + 6'(j), 32'hB0000000 | 32'(j));
            end else begin
                idle();
            end
            tick();
            ev = (j >= 1) && (j <= 16);
            ed = ev ? (32'hA5000000 | 32'(j - 1)) : 32'h0;
            cseen = cseen | l1_coll | l3_coll;
            if (l1_vld_a === 1'b1) run++;
            checks++; if (l1_vld_a !== ev || l1_d_a !== ed) begin errors++; $display("FAIL b2b_j%0d: vld %b d %h want %b %h", j, l1_vld_a, l1_d_a, ev, ed); end
        end
        checks++; if (run !== 16) begin errors++; $display("FAIL b2b_run: %0d vld cycles want 16", run); end
        checks++; if (cseen !== 1'b0) begin errors++; $display("FAIL b2b_coll: %b want 0", cseen); end
        set_b(1'b1, 1'b0, 6'h35, 32'h0);
        tick();
        idle();
        tick();
        checks++; if (l1_vld_b !== 1'b1 || l1_d_b !== 32'hB0000005) begin errors++; $display("FAIL b2b_wrchk: vld %b d %h want 1 b0000005", l1_vld_b, l1_d_b); end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        set_a(1'b1, 1'b0, 6'h13, 32'h0);
        set_b(1'b1, 1'b0, 6'h05, 32'h0);
        tick();
        set_a(1'b1, 1'b0, 6'h01, 32'h0);
        set_b(1'b1, 1'b0, 6'h02, 32'h0);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if ({l1_init, l3_init, l3_rdy_a} !== 3'b000) begin errors++; $display("FAIL mid_restart: init/rdy %b want 000", {l1_init, l3_init, l3_rdy_a}); end
        seen = l1_vld_a | l1_vld_b | l3_vld_a | l3_vld_b;
        for (int i = 1; i <= 16; i++) begin
            tick();
            seen = seen | l1_vld_a | l1_vld_b | l3_vld_a | l3_vld_b;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_discard: vld seen %b want 0", seen); end
        checks++; if (l3_init !== 1'b1) begin errors++; $display("FAIL mid_done: init %b want 1", l3_init); end
        set_a(1'b1, 1'b0, 6'h13, 32'h0);
        set_b(1'b1, 1'b0, 6'h05, 32'h0);
        tick();
        idle();
        tick();
        checks++; if (l1_vld_a !== 1'b1 || l1_d_a !== 32'h0 || l1_vld_b !== 1'b1 || l1_d_b !== 32'h0) begin errors++; $display("FAIL mid_zero_l1: vld %b%b d_a %h d_b %h want 11 0 0", l1_vld_a, l1_vld_b, l1_d_a, l1_d_b); end
        tick();
        tick();
        checks++; if (l3_vld_a !== 1'b1 || l3_d_a !== 32'h0 || l3_vld_b !== 1'b1 || l3_d_b !== 32'h0) begin errors++; $display("FAIL mid_zero_l3: vld %b%b d_a %h d_b %h want 11 0 0", l3_vld_a, l3_vld_b, l3_d_a, l3_d_b); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_clear_read();
        test_rd_latency();
        test_collision();
        test_bypass();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_sram_pipe.md
MULTI_SRAM_PIPE -- requirements
Module: multi_sram_pipe

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data width per port.
REQ-002 SHALL have parameter NRAMWIDHT, default 5, bank-select width; bank count NSRAM = 2^NRAMWIDHT.
REQ-003 SHALL have parameter AWIDTH, default 13, word-address width inside one bank.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal range 1..3, any other value an elaboration error.
REQ-005 SHALL have parameter CLR_ON_RST, default 1; 1 = zero all banks after reset.
REQ-006 SHALL have ports clk_in (in, 1, sole clock) and rst_n_in (in, 1, synchronous active-low reset).
REQ-007 SHALL have port-A inputs en_a_in (1, request), we_a_in (1, 1=write), addr_a_in (NRAMWIDHT+AWIDTH) and d_a_in (DWIDTH).
REQ-008 SHALL have port-A outputs rdy_a_out (1, request accepted this cycle), d_a_out (DWIDTH, read data) and vld_a_out (1, d_a_out valid).
REQ-009 SHALL have port-B ports en_b_in, we_b_in, addr_b_in, d_b_in, rdy_b_out, d_b_out and vld_b_out, identical to port A.
REQ-010 SHALL have outputs init_done_out (1, clear finished) and collision_out (1, write/write collision pulse).

Function
REQ-011 SHALL decode the bank as addr[NRAMWIDHT+AWIDTH-1:AWIDTH] and the word as addr[AWIDTH-1:0]; SHALL enable only the addressed bank per port.
REQ-012 SHALL implement NSRAM behavioural true-dual-port banks of 2^AWIDTH x DWIDTH, both ports on clk_in, 1-cycle internal read.
REQ-013 SHALL run FSM states CLEAR and RUN; reset enters CLEAR if CLR_ON_RST=1, else RUN.
REQ-014 In CLEAR: word counter 0..2^AWIDTH-1, writes zero at that word in all banks in parallel, one word per cycle; after the last word, next state RUN; CLEAR lasts exactly 2^AWIDTH cycles.
REQ-015 init_done_out SHALL be 0 in CLEAR and 1 in RUN; rdy_a_out and rdy_b_out SHALL equal init_done_out.
REQ-016 Requests (en=1) while rdy=0 SHALL be ignored, neither stored nor queued.
REQ-017 A write (en=1, we=1, rdy=1) SHALL update memory at that clock edge and SHALL produce no vld pulse.
REQ-018 A read accepted at edge T SHALL drive vld=1 and the data from edge T+RD_LAT until edge T+RD_LAT+1, i.e. exactly one cycle; back-to-back reads SHALL stream with vld high every cycle.
REQ-019 d_x_out SHALL be all-zero whenever vld_x_out=0.
REQ-020 Read data SHALL be piped through RD_LAT-1 extra register stages, carrying vld and the bank index alongside.
REQ-021 Same-port read one cycle after a write to the same address SHALL return the new data.
REQ-022 On same-cycle collision (full address equal, both en=1), both writes: port A data SHALL be stored, port B write dropped, and collision_out SHALL be 1 for the single following cycle.
REQ-023 On same-cycle collision, one write and one read: the read SHALL return the data being written (write-first bypass); collision_out SHALL stay 0.
REQ-024 Both ports reading the same address SHALL both return the stored data, no collision.
REQ-025 Accesses to different banks, or different words in one bank, SHALL proceed concurrently without interaction.

Reset
REQ-026 With rst_n_in=0 at an edge: FSM to CLEAR (or RUN per CLR_ON_RST), counter=0, every pipeline vld=0, d_a_out=d_b_out=0, collision_out=0, init_done_out=0 (1 if CLR_ON_RST=0), rdy as REQ-015.
REQ-027 Reset mid-operation SHALL discard all in-flight reads, with no vld afterward for them; memory contents are then cleared by CLEAR or left unchanged if CLR_ON_RST=0.

Verification (bench: DWIDTH=32, NRAMWIDHT=2, AWIDTH=4)
REQ-028 Reset release, CLR_ON_RST=1 -> init_done_out/rdy rise exactly 16 cycles later; read of addr 0x2F afterwards returns 0x00000000 with vld 1 cycle after accept (RD_LAT=1).
REQ-029 RD_LAT=3: A writes 0xDEADBEEF to 0x13, next cycle A reads 0x13 -> vld_a_out high exactly 3 cycles after the read edge, d_a_out=0xDEADBEEF, 0 elsewhere.
REQ-030 A writes 0x11111111 and B writes 0x22222222 to 0x05 in one cycle -> collision_out=1 for one cycle; later read of 0x05 = 0x11111111.
REQ-031 A writes 0xCAFEF00D to 0x3A while B reads 0x3A in the same cycle -> d_b_out=0xCAFEF00D with vld_b_out.
REQ-032 A streams reads of 0x00..0x0F while B streams writes to bank 3 -> 16 consecutive vld_a_out cycles, correct data, no collision.
REQ-033 rst_n_in low for 1 cycle with 2 reads in flight (RD_LAT=3) -> no vld on either port for those reads, CLEAR restarts, previously written data reads back 0.
